// File: rtl/full_logic_ctrl.sv
// Flow-control and pop scheduler for the full_logic datapath: phase FSM,
// hysteresis backpressure and round-robin arbitration of the D0/D1 FIFOs.
module full_logic_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 4,
    parameter int TH_HIGH_DEF = 6,
    parameter int TH_LOW_DEF  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic [CNT_W-1:0] th_high_in,
    input  logic [CNT_W-1:0] th_low_in,
    input  logic             src_valid,
    input  logic [CNT_W-1:0] d0_count,
    input  logic [CNT_W-1:0] d1_count,
    input  logic             d0_ready,
    input  logic             d1_ready,
    input  logic             error_D0,
    input  logic             error_D1,
    output logic             wr_enable,
    output logic             D0_pop,
    output logic             D1_pop,
    output logic             pause,
    output logic [CNT_W-1:0] th_high,
    output logic [CNT_W-1:0] th_low,
    output logic [2:0]       state,
    output logic             idle_out,
    output logic             active_out,
    output logic             error_out
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] TH_HIGH_C  = CNT_W'(TH_HIGH_DEF);
    localparam logic [CNT_W-1:0] TH_LOW_C   = CNT_W'(TH_LOW_DEF);
    localparam logic             GRANT_D0   = 1'b0;
    localparam logic             GRANT_D1   = 1'b1;

    state_t           state_q, state_d;
    logic             pause_q, pause_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] th_high_q, th_high_d;
    logic [CNT_W-1:0] th_low_q, th_low_d;
    logic             cand0, cand1;
    logic             pop0, pop1;
    logic             any_err;
    logic             counts_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RESET;
            pause_q      <= 1'b0;
            last_grant_q <= GRANT_D1;
            th_high_q    <= TH_HIGH_C;
            th_low_q     <= TH_LOW_C;
        end else begin
            state_q      <= state_d;
            pause_q      <= pause_d;
            last_grant_q <= last_grant_d;
            th_high_q    <= th_high_d;
            th_low_q     <= th_low_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        th_high_d   = th_high_q;
        th_low_d    = th_low_q;
        any_err     = error_D0 | error_D1;
        counts_zero = (d0_count == '0) && (d1_count == '0);

        case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    th_high_d = th_high_in;
                    th_low_d  = th_low_in;
                end else if ((th_low_q < th_high_q) && (th_high_q <= DEPTH_C)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            ST_IDLE: begin
                if (init)
                    state_d = ST_INIT;
                else if (src_valid || !counts_zero)
                    state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!src_valid && counts_zero)
                    state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase

        // A datapath error beats every other transition except leaving RESET.
        if (state_q != ST_RESET && any_err)
            state_d = ST_ERROR;
    end

    always_comb begin
        pause_d = pause_q;
        if (state_q == ST_ACTIVE) begin
            if ((d0_count >= th_high_q) || (d1_count >= th_high_q))
                pause_d = 1'b1;
            else if ((d0_count <= th_low_q) && (d1_count <= th_low_q))
                pause_d = 1'b0;
        end
        if (state_d == ST_ERROR)
            pause_d = 1'b0;
    end

    // On a tie the FIFO that was not served last wins.
    always_comb begin
        cand0        = (state_q == ST_ACTIVE) && (d0_count != '0) && d0_ready;
        cand1        = (state_q == ST_ACTIVE) && (d1_count != '0) && d1_ready;
        pop0         = 1'b0;
        pop1         = 1'b0;
        last_grant_d = last_grant_q;
        if (cand0 && cand1) begin
            pop0 = (last_grant_q == GRANT_D1);
            pop1 = (last_grant_q == GRANT_D0);
        end else begin
            pop0 = cand0;
            pop1 = cand1;
        end
        if (pop0)
            last_grant_d = GRANT_D0;
        else if (pop1)
            last_grant_d = GRANT_D1;
    end

    assign wr_enable  = src_valid & ~pause_q & (state_q == ST_ACTIVE);
    assign D0_pop     = pop0;
    assign D1_pop     = pop1;
    assign pause      = pause_q;
    assign th_high    = th_high_q;
    assign th_low     = th_low_q;
    assign state      = state_q;
    assign idle_out   = (state_q == ST_IDLE);
    assign active_out = (state_q == ST_ACTIVE);
    assign error_out  = (state_q == ST_ERROR);

endmodule

// File: tb/tb_full_logic_ctrl.sv
// Directed self-checking bench for full_logic_ctrl: each task drives one
// scenario and compares outputs against hand-computed values.
module tb_full_logic_ctrl;

    logic       clk;
    logic       reset;
    logic       init;
    logic [3:0] th_high_in;
    logic [3:0] th_low_in;
    logic       src_valid;
    logic [3:0] d0_count;
    logic [3:0] d1_count;
    logic       d0_ready;
    logic       d1_ready;
    logic       error_D0;
    logic       error_D1;
    logic       wr_enable;
    logic       D0_pop;
    logic       D1_pop;
    logic       pause;
    logic [3:0] th_high;
    logic [3:0] th_low;
    logic [2:0] state;
    logic       idle_out;
    logic       active_out;
    logic       error_out;

    int checks;
    int failures;

    full_logic_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .th_high_in (th_high_in),
        .th_low_in  (th_low_in),
        .src_valid  (src_valid),
        .d0_count   (d0_count),
        .d1_count   (d1_count),
        .d0_ready   (d0_ready),
        .d1_ready   (d1_ready),
        .error_D0   (error_D0),
        .error_D1   (error_D1),
        .wr_enable  (wr_enable),
        .D0_pop     (D0_pop),
        .D1_pop     (D1_pop),
        .pause      (pause),
        .th_high    (th_high),
        .th_low     (th_low),
        .state      (state),
        .idle_out   (idle_out),
        .active_out (active_out),
        .error_out  (error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so sampling stays off the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        init       = 1'b0;
        th_high_in = 4'd0;
        th_low_in  = 4'd0;
        src_valid  = 1'b0;
        d0_count   = 4'd0;
        d1_count   = 4'd0;
        d0_ready   = 1'b0;
        d1_ready   = 1'b0;
        error_D0   = 1'b0;
        error_D1   = 1'b0;
    endtask

    task automatic reset_to_idle();
        clear_inputs();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        init       = 1'b1;
        th_high_in = 4'd5;
        th_low_in  = 4'd1;
        reset      = 1'b1;
        #2;
        reset = 1'b0;
        step();
        step();
        checks++;
        if ({state, pause, wr_enable, D0_pop, D1_pop, idle_out, active_out, error_out} !== {3'd0, 7'b0}) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got state=%0d pause=%b wr=%b pops=%b%b flags=%b%b%b want state=0 all zero",
                     state, pause, wr_enable, D0_pop, D1_pop, idle_out, active_out, error_out);
        end
        checks++;
        if ({th_high, th_low} !== {4'd6, 4'd2}) begin
            failures++;
            $display("[TB] FAIL reset_thresholds: got %0d/%0d want 6/2", th_high, th_low);
        end
        reset = 1'b1;
        step();
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("[TB] FAIL reset_to_init: got state=%0d want 1", state);
        end
        step();
        checks++;
        if ({state, th_high, th_low} !== {3'd1, 4'd5, 4'd1}) begin
            failures++;
            $display("[TB] FAIL init_load: got state=%0d th=%0d/%0d want state=1 th=5/1", state, th_high, th_low);
        end
        init = 1'b0;
        th_high_in = 4'd9;
        step();
        checks++;
        if ({state, idle_out, th_high, th_low} !== {3'd2, 1'b1, 4'd5, 4'd1}) begin
            failures++;
            $display("[TB] FAIL init_to_idle: got state=%0d idle=%b th=%0d/%0d want state=2 idle=1 th=5/1",
                     state, idle_out, th_high, th_low);
        end
    endtask

    task automatic test_init_error();
        init       = 1'b1;
        th_high_in = 4'd4;
        th_low_in  = 4'd4;
        step();
        step();
        init = 1'b0;
        step();
        checks++;
        if ({state, error_out, idle_out} !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL init_equal_th_error: got state=%0d err=%b want state=4 err=1", state, error_out);
        end
        init = 1'b1;
        src_valid = 1'b1;
        step();
        step();
        checks++;
        if ({state, wr_enable} !== {3'd4, 1'b0}) begin
            failures++;
            $display("[TB] FAIL error_sticky: got state=%0d wr=%b want state=4 wr=0", state, wr_enable);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({state, error_out, th_high, th_low} !== {3'd0, 1'b0, 4'd6, 4'd2}) begin
            failures++;
            $display("[TB] FAIL async_reset_from_error: got state=%0d err=%b th=%0d/%0d want state=0 err=0 th=6/2",
                     state, error_out, th_high, th_low);
        end
        reset = 1'b1;
    endtask

    task automatic test_init_bounds();
        reset_to_idle();
        checks++;
        if ({state, th_high, th_low} !== {3'd2, 4'd6, 4'd2}) begin
            failures++;
            $display("[TB] FAIL default_to_idle: got state=%0d th=%0d/%0d want state=2 th=6/2", state, th_high, th_low);
        end
        init = 1'b1; th_high_in = 4'd8; th_low_in = 4'd7;
        step();
        step();
        init = 1'b0;
        step();
        checks++;
        if ({state, th_high, th_low} !== {3'd2, 4'd8, 4'd7}) begin
            failures++;
            $display("[TB] FAIL th_depth_ok: got state=%0d th=%0d/%0d want state=2 th=8/7", state, th_high, th_low);
        end
        init = 1'b1; th_high_in = 4'd9; th_low_in = 4'd1;
        step();
        step();
        init = 1'b0;
        step();
        checks++;
        if (state !== 3'd4) begin
            failures++;
            $display("[TB] FAIL th_over_depth: got state=%0d want 4", state);
        end
    endtask

    task automatic test_pause();
        reset_to_idle();
        src_valid = 1'b1;
        step();
        checks++;
        if ({state, active_out, wr_enable} !== {3'd3, 1'b1, 1'b1}) begin
            failures++;
            $display("[TB] FAIL enter_active: got state=%0d act=%b wr=%b want 3/1/1", state, active_out, wr_enable);
        end
        for (int k = 0; k <= 6; k++) begin
            d0_count = 4'(k);
            step();
            checks++;
            if ({pause, wr_enable} !== {(k >= 6), (k < 6)}) begin
                failures++;
                $display("[TB] FAIL pause_ramp_%0d: got pause=%b wr=%b want pause=%b wr=%b",
                         k, pause, wr_enable, (k >= 6), (k < 6));
            end
        end
        d0_count = 4'd3;
        step();
        checks++;
        if ({pause, wr_enable} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL pause_hold: got pause=%b wr=%b want 1/0", pause, wr_enable);
        end
        d0_count = 4'd2;
        step();
        checks++;
        if ({pause, wr_enable} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL pause_release: got pause=%b wr=%b want 0/1", pause, wr_enable);
        end
        d1_count = 4'd7;
        step();
        d1_count = 4'd4;
        error_D0 = 1'b1;
        step();
        error_D0 = 1'b0;
        checks++;
        if ({state, pause} !== {3'd4, 1'b0}) begin
            failures++;
            $display("[TB] FAIL pause_clear_on_error: got state=%0d pause=%b want 4/0", state, pause);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp0;
        reset_to_idle();
        exp0 = 4'b0101;
        d0_count = 4'd3; d1_count = 4'd3;
        d0_ready = 1'b1; d1_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({D0_pop, D1_pop} !== {exp0[i], ~exp0[i]}) begin
                failures++;
                $display("[TB] FAIL rr_pop_%0d: got D0=%b D1=%b want D0=%b D1=%b",
                         i, D0_pop, D1_pop, exp0[i], ~exp0[i]);
            end
            step();
        end
    endtask

    task automatic test_single_pop();
        reset_to_idle();
        src_valid = 1'b1;
        d0_count = 4'd1; d0_ready = 1'b1; d1_ready = 1'b0;
        step();
        checks++;
        if ({D0_pop, D1_pop, wr_enable} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL single_pop_d0: got D0=%b D1=%b wr=%b want 1/0/1", D0_pop, D1_pop, wr_enable);
        end
        d0_count = 4'd0;
        d1_ready = 1'b1;
        #1;
        checks++;
        if ({D0_pop, D1_pop} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL no_pop_empty: got D0=%b D1=%b want 0/0", D0_pop, D1_pop);
        end
        d1_count = 4'd2;
        #1;
        checks++;
        if ({D0_pop, D1_pop} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL single_pop_d1: got D0=%b D1=%b want 0/1", D0_pop, D1_pop);
        end
        src_valid = 1'b0; d1_count = 4'd0;
        step();
        checks++;
        if ({state, idle_out} !== {3'd2, 1'b1}) begin
            failures++;
            $display("[TB] FAIL active_to_idle: got state=%0d idle=%b want 2/1", state, idle_out);
        end
    endtask

    task automatic test_error_override();
        reset_to_idle();
        init = 1'b1;
        error_D1 = 1'b1;
        step();
        error_D1 = 1'b0;
        checks++;
        if ({state, error_out} !== {3'd4, 1'b1}) begin
            failures++;
            $display("[TB] FAIL error_beats_init: got state=%0d err=%b want 4/1", state, error_out);
        end
        init = 1'b0; src_valid = 1'b1;
        d0_count = 4'd7; d1_count = 4'd7; d0_ready = 1'b1; d1_ready = 1'b1;
        step();
        checks++;
        if ({state, wr_enable, D0_pop, D1_pop, pause} !== {3'd4, 4'b0000}) begin
            failures++;
            $display("[TB] FAIL error_gates_outputs: got state=%0d wr=%b pops=%b%b pause=%b want 4 and all zero",
                     state, wr_enable, D0_pop, D1_pop, pause);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_init_error();
        test_init_bounds();
        test_pause();
        test_round_robin();
        test_single_pop();
        test_error_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
